// File: rtl/ex_muldiv_seq_pkg.sv
// ============================================================================
// Module : ex_muldiv_seq_pkg
// Brief  : Shared RV32M func3 encodings, FSM states and operand-sign decode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ex_muldiv_seq_pkg;

  localparam int MD_XLEN = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic opASigned(input logic [2:0] f);
    return (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
  endfunction

  function automatic logic opBSigned(input logic [2:0] f);
    return (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_seq_step.sv
// ============================================================================
// Module : ex_muldiv_seq_step
// Brief  : One radix-2 iteration: shift-add multiply or restoring divide.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_muldiv_seq_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] accHi,
  input  logic            accLoMsb,
  input  logic            accLoLsb,
  input  logic [XLEN-1:0] operand,
  input  logic            isDiv,
  output logic [XLEN-1:0] nextHi,
  output logic            outBit
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_trial;
  logic          w_fits;

  assign w_sum     = {1'b0, accHi} + (accLoLsb ? {1'b0, operand} : '0);
  assign w_shifted = {accHi, accLoMsb};
  assign w_trial   = w_shifted - {1'b0, operand};
  assign w_fits    = ~w_trial[XLEN];

  // Multiply: outBit is the sum LSB that shifts into the low word.
  // Divide:   outBit is the quotient bit that shifts in at the bottom.
  always_comb begin
    nextHi = w_sum[XLEN:1];
    outBit = w_sum[0];
    if (isDiv) begin
      nextHi = w_fits ? w_trial[XLEN-1:0] : w_shifted[XLEN-1:0];
      outBit = w_fits;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_muldiv_seq.sv
// ============================================================================
// Module : ex_muldiv_seq
// Brief  : Fixed-latency iterative RV32M multiply/divide sequencer for EX.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_muldiv_seq
  import ex_muldiv_seq_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [4:0]      rdIn,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rdOut
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_func3;
  logic [4:0]        r_rd;
  logic              r_negA;
  logic              r_negB;
  logic [XLEN-1:0]   r_operand;
  logic [2*XLEN-1:0] r_acc;

  logic              w_accept;
  logic              w_aNeg;
  logic              w_bNeg;
  logic [XLEN-1:0]   w_absA;
  logic [XLEN-1:0]   w_absB;
  logic              w_isDiv;
  logic [XLEN-1:0]   w_nextHi;
  logic              w_outBit;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fixResult;

  assign w_accept = start && !flush;
  assign w_aNeg   = opASigned(func3) && opA[XLEN-1];
  assign w_bNeg   = opBSigned(func3) && opB[XLEN-1];
  assign w_absA   = w_aNeg ? -opA : opA;
  assign w_absB   = w_bNeg ? -opB : opB;
  assign w_isDiv  = r_func3[2];

  assign stall = ((r_state == ST_IDLE) && w_accept) ||
                 (r_state == ST_CALC) || (r_state == ST_FIXUP);
  assign busy  = (r_state != ST_IDLE);

  ex_muldiv_seq_step #(
    .XLEN(XLEN)
  ) u_step (
    .accHi    (r_acc[2*XLEN-1:XLEN]),
    .accLoMsb (r_acc[XLEN-1]),
    .accLoLsb (r_acc[0]),
    .operand  (r_operand),
    .isDiv    (w_isDiv),
    .nextHi   (w_nextHi),
    .outBit   (w_outBit)
  );

  // Magnitudes were iterated; restore signs. A zero divisor keeps the
  // all-ones quotient the restoring loop naturally produces.
  always_comb begin
    w_prod = (r_negA ^ r_negB) ? -r_acc : r_acc;
    w_quot = ((r_negA ^ r_negB) && (r_operand != '0)) ? -r_acc[XLEN-1:0]
                                                      : r_acc[XLEN-1:0];
    w_rem  = r_negA ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    case (r_func3)
      MD_MUL:                       w_fixResult = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_fixResult = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              w_fixResult = w_quot;
      default:                      w_fixResult = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_func3   <= '0;
      r_rd      <= '0;
      r_negA    <= 1'b0;
      r_negB    <= 1'b0;
      r_operand <= '0;
      r_acc     <= '0;
      done      <= 1'b0;
      result    <= '0;
      rdOut     <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_CALC;
            r_cnt     <= '0;
            r_func3   <= func3;
            r_rd      <= rdIn;
            r_negA    <= w_aNeg;
            r_negB    <= w_bNeg;
            // Divide: low word holds the dividend; multiply: the multiplier.
            r_operand <= func3[2] ? w_absB : w_absA;
            r_acc     <= {{XLEN{1'b0}}, (func3[2] ? w_absA : w_absB)};
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_isDiv) begin
            r_acc <= {w_nextHi, r_acc[XLEN-2:0], w_outBit};
          end else begin
            r_acc <= {w_nextHi, w_outBit, r_acc[XLEN-1:1]};
          end
          if (r_cnt == CNT_W'(XLEN-1)) begin
            r_state <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          result  <= w_fixResult;
          rdOut   <= r_rd;
          done    <= 1'b1;
          r_state <= ST_DONE;
        end
        default: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_seq.sv
// ============================================================================
// Module : tb_ex_muldiv_seq
// Brief  : Self-checking bench: directed table, corner sequences, random ops.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  func3 = 3'd0;
  logic [31:0] opA = 32'd0;
  logic [31:0] opB = 32'd0;
  logic [4:0]  rdIn = 5'd0;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rdOut;

  int checks = 0;
  int errors = 0;

  ex_muldiv_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .func3  (func3),
    .opA    (opA),
    .opB    (opB),
    .rdIn   (rdIn),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rdOut  (rdOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  // Architectural RV32M results straight from the ISA definition.
  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          ps;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned pu;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin ps = sa * sb; return ps[31:0]; end
      3'd1: begin ps = sa * sb; return ps[63:32]; end
      3'd2: begin ps = sa * longint'(ub); return ps[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        ps = sa / sb;
        return ps[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        pu = ua / ub;
        return pu[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        ps = sa % sb;
        return ps[31:0];
      end
      default: begin
        if (b == 0) return a;
        pu = ua % ub;
        return pu[31:0];
      end
    endcase
  endfunction

  // Issue one op from IDLE and check latency, stall profile, result and rd.
  task automatic runOp(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int cyc;
    bit stallOk;
    start = 1'b1; func3 = f; opA = a; opB = b; rdIn = rd;
    #1;
    stallOk = (stall === 1'b1);
    nextCyc();
    start = 1'b0;
    opA = $urandom; opB = $urandom; rdIn = 5'($urandom);
    #1;
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      if (stall !== 1'b1) stallOk = 1'b0;
      nextCyc();
      cyc++;
    end
    chk({name, " latency"}, 64'(cyc), 64'd34);
    chk({name, " stall"}, {63'd0, stallOk}, 64'd1);
    chk({name, " stallDone"}, {63'd0, stall}, 64'd0);
    chk({name, " result"}, {32'd0, result}, {32'd0, exp});
    chk({name, " rdOut"}, {59'd0, rdOut}, {59'd0, rd});
    nextCyc();
    chk({name, " idleAfter"}, {62'd0, done, busy}, 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] held;
    int doneCnt;
    int doneCyc;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rf;

    vecs.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{3'd5, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF});
    vecs.push_back('{3'd7, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678});
    vecs.push_back('{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9});

    // Reset state
    repeat (3) nextCyc();
    chk("reset outputs", {29'd0, stall, busy, done, result, rdOut[2:0]}, 64'd0);
    chk("reset rdOut", {59'd0, rdOut}, 64'd0);
    rst_n = 1'b1;
    nextCyc();

    foreach (vecs[i]) begin
      runOp($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp);
    end
    held = vecs[vecs.size()-1].exp;

    // Flush at cycle 10
    start = 1'b1; func3 = 3'd0; opA = 32'd9; opB = 32'd9; rdIn = 5'd3;
    nextCyc();
    start = 1'b0;
    repeat (9) nextCyc();
    flush = 1'b1;
    nextCyc();
    flush = 1'b0;
    #1;
    chk("flush busy", {63'd0, busy}, 64'd0);
    doneCnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) doneCnt++;
      nextCyc();
    end
    chk("flush noDone", 64'(doneCnt), 64'd0);
    chk("flush resultHeld", {32'd0, result}, {32'd0, held});

    // start and flush in the same IDLE cycle
    start = 1'b1; flush = 1'b1; func3 = 3'd0; opA = 32'd2; opB = 32'd3;
    #1;
    chk("startFlush stall", {63'd0, stall}, 64'd0);
    nextCyc();
    start = 1'b0; flush = 1'b0;
    #1;
    chk("startFlush busy", {63'd0, busy}, 64'd0);

    // Re-pulsed start at cycle 5 must be ignored
    start = 1'b1; func3 = 3'd0; opA = 32'd3; opB = 32'd5; rdIn = 5'd7;
    nextCyc();
    start = 1'b0;
    doneCnt = 0; doneCyc = -1;
    for (int c = 1; c < 45; c++) begin
      start = (c == 5);
      if (c == 5) begin func3 = 3'd5; opA = 32'd100; opB = 32'd3; rdIn = 5'd9; end
      #1;
      if (done === 1'b1) begin doneCnt++; doneCyc = c; end
      if (c == 34) begin
        chk("repulse result", {32'd0, result}, 64'd15);
        chk("repulse rdOut", {59'd0, rdOut}, 64'd7);
      end
      nextCyc();
    end
    start = 1'b0;
    chk("repulse doneCount", 64'(doneCnt), 64'd1);
    chk("repulse doneCycle", 64'(doneCyc), 64'd34);

    // Flush during DONE still returns to IDLE
    start = 1'b1; func3 = 3'd3; opA = 32'd4; opB = 32'd6; rdIn = 5'd11;
    nextCyc();
    start = 1'b0;
    for (int c = 1; c < 34; c++) nextCyc();
    chk("doneFlush done", {63'd0, done}, 64'd1);
    flush = 1'b1;
    nextCyc();
    flush = 1'b0;
    #1;
    chk("doneFlush idle", {62'd0, done, busy}, 64'd0);

    // Reset at cycle 20 clears everything
    start = 1'b1; func3 = 3'd4; opA = 32'd77; opB = 32'd7; rdIn = 5'd20;
    nextCyc();
    start = 1'b0;
    for (int c = 1; c < 20; c++) nextCyc();
    rst_n = 1'b0;
    nextCyc();
    #1;
    chk("midReset ctl", {61'd0, stall, busy, done}, 64'd0);
    chk("midReset data", {27'd0, rdOut, result}, 64'd0);
    rst_n = 1'b1;
    doneCnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) doneCnt++;
      nextCyc();
    end
    chk("midReset noDone", 64'(doneCnt), 64'd0);
    runOp("postReset", 3'd4, 32'd77, 32'd7, 5'd20, 32'd11);

    // Randomized ops against the reference model
    for (int n = 0; n < 60; n++) begin
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      runOp($sformatf("rnd%0d f%0d", n, rf), rf, ra, rb, 5'($urandom), refModel(rf, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
